// File: rtl/cpu_wb_arbiter.sv
// Two-master (IF/MEM) to one-slave Wishbone arbiter with alternating tie-break.
// Optional stall watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
module cpu_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [1:0]              grant_o,
  output logic                    bus_timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;  // 0 = m0, 1 = m1
  logic   timeout_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      grant_o    <= 2'b00;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      // grant_o tracks the registered state, so it never sees master inputs directly
      unique case (state_nxt)
        GNT0:    grant_o <= 2'b01;
        GNT1:    grant_o <= 2'b10;
        default: grant_o <= 2'b00;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        in_gnt, sel_cyc, sel_stb;

  assign in_gnt  = (state == GNT0) || (state == GNT1);
  assign sel_cyc = (state == GNT1) ? m1_cyc_i : m0_cyc_i;
  assign sel_stb = (state == GNT1) ? m1_stb_i : m0_stb_i;
  assign timeout_hit = in_gnt && sel_stb && !s_ack_i &&
                       (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus_timeout_o = timeout_hit;

  always_ff @(posedge clk) begin
    if (!reset || !in_gnt || !sel_cyc || s_ack_i || timeout_hit)
      to_cnt <= '0;
    else if (sel_stb)
      to_cnt <= to_cnt + 16'd1;
  end
`else
  assign timeout_hit   = 1'b0;
  assign bus_timeout_o = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    s_we_o         = 1'b0;
    s_adr_o        = '0;
    s_dat_o        = '0;
    s_sel_o        = '0;
    m0_ack_o       = 1'b0;
    m0_dat_o       = '0;
    m1_ack_o       = 1'b0;
    m1_dat_o       = '0;

    unique case (state)
      IDLE: begin
        if (m1_cyc_i && (!m0_cyc_i || !last_grant)) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end else if (m0_cyc_i) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end
      end
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        if (timeout_hit) begin
          s_cyc_o   = 1'b0;
          s_stb_o   = 1'b0;
          m0_ack_o  = 1'b1;
          m0_dat_o  = '0;
          state_nxt = DRAIN;
        end else if (!m0_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        if (timeout_hit) begin
          s_cyc_o   = 1'b0;
          s_stb_o   = 1'b0;
          m1_ack_o  = 1'b1;
          m1_dat_o  = '0;
          state_nxt = DRAIN;
        end else if (!m1_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // last_grant identifies the master whose cycle was cut short
        if (!(last_grant ? m1_cyc_i : m0_cyc_i))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed bench for cpu_wb_arbiter; acks are checked against a scoreboard queue.
module tb_cpu_wb_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic [SW-1:0] m0_sel_i;
  logic          m0_ack_o;
  logic [DW-1:0] m0_dat_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic [SW-1:0] m1_sel_i;
  logic          m1_ack_o;
  logic [DW-1:0] m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic          s_ack_i;
  logic [DW-1:0] s_dat_i;
  logic [1:0]    grant_o;
  logic          bus_timeout_o;

  cpu_wb_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .bus_timeout_o(bus_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave acks this cycle; the expected recipient and data go on the scoreboard first.
  task automatic ack_and_check(input logic port, input logic [DW-1:0] d);
    exp_t e;
    sb.push_back('{port: port, data: d});
    s_ack_i = 1'b1;
    s_dat_i = d;
    #1;
    chk("ack_vec", {m1_ack_o, m0_ack_o}, port ? 2'b10 : 2'b01);
    if (m0_ack_o || m1_ack_o) begin
      e = sb.pop_front();
      chk("ack_dat", m1_ack_o ? m1_dat_o : m0_dat_o, e.data);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"}, grant_o, 2'b00);
    chk({tag, "_scyc"}, {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
    chk({tag, "_sbus"}, {s_adr_o, s_sel_o}, '0);
    chk({tag, "_acks"}, {m1_ack_o, m0_ack_o, bus_timeout_o}, 3'b000);
    chk({tag, "_mdat"}, {m1_dat_o, m0_dat_o}, '0);
  endtask

  initial begin
    reset = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
    m0_adr_i = 32'h0000_2000; m0_dat_i = 32'h0; m0_sel_i = 4'hF;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
    m1_adr_i = 32'h0000_1000; m1_dat_i = 32'h0; m1_sel_i = 4'hF;
    s_ack_i = 1'b1; s_dat_i = 32'hA5A5_A5A5;

    // Reset held with both masters requesting and a stray slave ack
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 check_quiet("reset");
    end
    s_ack_i = 1'b0;
    reset   = 1'b1;
    tick();
    chk("post_reset_grant", grant_o, 2'b10);
    chk("post_reset_adr", s_adr_o, 32'h0000_1000);

    // Tie alternation: each master drops cyc with its ack, re-requests in the gap
    for (int i = 0; i < 4; i++) begin
      logic p;
      p = (i % 2 == 0);
      chk("tie_grant", grant_o, p ? 2'b10 : 2'b01);
      if (p) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
      else   begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
      if (i == 3) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
      ack_and_check(p, 32'h100 + i);
      tick();
      if (i < 3) begin
        if (p) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
        else   begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
      end
      #1 check_quiet("tie_gap");
      s_ack_i = 1'b0;
      tick();
    end
    check_quiet("tie_done");

    // Single IF read, slave acks on the third granted cycle
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h8000_0000;
    tick();
    chk("if_grant", grant_o, 2'b01);
    chk("if_sbus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o}, {3'b110, 32'h8000_0000});
    tick();
    chk("if_stall", {m1_ack_o, m0_ack_o}, 2'b00);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    ack_and_check(1'b0, 32'h0000_0013);
    tick();
    s_ack_i = 1'b0;
    #1 check_quiet("if_gap");

    // Data write pass-through
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 32'h8040_0004; m1_dat_i = 32'hDEAD_BEEF; m1_sel_i = 4'hF;
    tick();
    chk("wr_grant", grant_o, 2'b10);
    chk("wr_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    chk("wr_bus", {s_adr_o, s_dat_o, s_sel_o}, {32'h8040_0004, 32'hDEAD_BEEF, 4'hF});
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    ack_and_check(1'b1, 32'h0);
    tick();
    s_ack_i = 1'b0;
    #1 check_quiet("wr_gap");

    // Preemption: m1 requests while m0 owns the bus
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_3000;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_4000; m1_dat_i = 32'h0;
    #1;
    chk("pre_hold0", {grant_o, s_adr_o}, {2'b01, 32'h0000_3000});
    tick();
    chk("pre_hold1", {grant_o, s_adr_o}, {2'b01, 32'h0000_3000});
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    ack_and_check(1'b0, 32'h0000_0033);
    tick();
    s_ack_i = 1'b0;
    #1 chk("pre_gap", grant_o, 2'b00);
    tick();
    chk("pre_m1", {grant_o, s_cyc_o, s_adr_o}, {2'b10, 1'b1, 32'h0000_4000});

    // m1 now stalls with no slave ack
    s_dat_i = 32'hCAFE_F00D;
`ifdef WB_ARB_TIMEOUT_EN
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("stall_ack", {m1_ack_o, m0_ack_o}, 2'b00);
      chk("stall_to", bus_timeout_o, 1'b0);
      tick();
    end
    #1;
    chk("to_ack", {m1_ack_o, m0_ack_o}, 2'b10);
    chk("to_dat", m1_dat_o, 32'h0);
    chk("to_pulse", bus_timeout_o, 1'b1);
    chk("to_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    tick();
    s_ack_i = 1'b1;
    #1 check_quiet("drain");
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    #1 check_quiet("drain_exit");
`else
    for (int j = 0; j < 10; j++) begin
      #1;
      chk("stall_ack", {m1_ack_o, m0_ack_o}, 2'b00);
      chk("stall_to", bus_timeout_o, 1'b0);
      chk("stall_hold", {grant_o, s_cyc_o}, {2'b10, 1'b1});
      tick();
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    #1 check_quiet("stall_exit");
`endif

    // Reset in the middle of a granted cycle: no ack escapes afterwards
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    chk("mid_grant", grant_o, 2'b01);
    reset = 1'b0; s_ack_i = 1'b1;
    tick();
    #1 check_quiet("mid_reset");
    s_ack_i = 1'b0; reset = 1'b1;
    tick();
    chk("mid_regrant", grant_o, 2'b01);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
